// File: rtl/store_serializer_if.sv
// Store request / RAM write-port bundle for the store serializer.
// The slave modport is the serializer's view. The master modport is the
// load/store-unit side that drives requests and watches the RAM port.
interface store_serializer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  is_byte;
    logic                  is_half;
    logic                  is_word;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [7:0]            mem_dout;
    logic                  mem_wr;
    logic                  done;

    modport slave (
        input  req_valid, req_addr, req_data, is_byte, is_half, is_word,
        output req_ready, mem_a, mem_dout, mem_wr, done
    );

    modport master (
        output req_valid, req_addr, req_data, is_byte, is_half, is_word,
        input  req_ready, mem_a, mem_dout, mem_wr, done
    );
endinterface

// File: rtl/store_serializer.sv
// Store serializer: latches one SB/SH/SW request and writes it little-endian,
// one byte per cycle, over an 8-bit RAM write port. A low rdy_in freezes it.
module store_serializer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    store_serializer_if.slave   bus
);
    typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_base,  w_base_nxt;
    logic [DATA_WIDTH-1:0] r_data,  w_data_nxt;
    logic [1:0]            r_last,  w_last_nxt;   // index of the final byte (N-1)
    logic [1:0]            r_idx,   w_idx_nxt;
    logic [1:0]            w_req_last;
    logic                  w_write;
    logic                  w_final;
    logic [DATA_WIDTH-1:0] w_shift;

    // Size decode: byte wins over half; word or no qualifier means four bytes
    always_comb begin
        if (bus.is_byte)
            w_req_last = 2'd0;
        else if (bus.is_half)
            w_req_last = 2'd1;
        else
            w_req_last = 2'd3;
    end

    // Next-state and write-strobe logic; nothing moves while rdy_in is low
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_idx_nxt   = r_idx;
        w_write     = 1'b0;
        w_final     = 1'b0;
        if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        w_base_nxt  = bus.req_addr;
                        w_data_nxt  = bus.req_data;
                        w_last_nxt  = w_req_last;
                        w_idx_nxt   = 2'd0;
                        w_state_nxt = S_WRITE;
                    end
                end
                S_WRITE: begin
                    w_write = 1'b1;
                    w_final = (r_idx == r_last);
                    if (w_final) begin
                        w_idx_nxt   = 2'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and latched request registers; reset abandons any partial store
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_data  <= '0;
            r_last  <= 2'd0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Bytes above the requested width are never selected, which truncates the store
    assign w_shift      = r_data >> {r_idx, 3'b000};
    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.mem_wr    = w_write;
    assign bus.done      = w_final;
    assign bus.mem_a     = w_write ? (r_base + ADDR_WIDTH'(r_idx)) : '0;
    assign bus.mem_dout  = w_write ? w_shift[7:0] : 8'h00;
endmodule

// File: tb/tb_store_serializer.sv
// Self-checking bench for store_serializer: directed cases followed by
// randomized stores, checked against a byte-list model of each store.
module tb_store_serializer;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   tests = 0;
    int   fails = 0;

    store_serializer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    store_serializer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Number of bytes a store writes, from the size qualifiers alone
    function automatic int model_n(input bit b, input bit h);
        if (b) return 1;
        if (h) return 2;
        return 4;
    endfunction

    // Idle cycles: port must be quiet and ready regardless of rdy_in
    task automatic idle_check(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            rst = 1'b0;
            rdy = 1'($urandom_range(0, 1));
            bus.req_valid = 1'b0;
            #1;
            chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
            chk({tag, "_wr"},    32'(bus.mem_wr),    32'd0);
            chk({tag, "_a"},     bus.mem_a,          32'd0);
            chk({tag, "_dout"},  32'(bus.mem_dout),  32'd0);
            chk({tag, "_done"},  32'(bus.done),      32'd0);
        end
    endtask

    // One complete store: handshake, optional stall of stall_len cycles before
    // byte stall_at, and optional scrambling of req_* with req_valid held high
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input bit b, input bit h, input bit w,
                            input int stall_at, input int stall_len, input bit hold);
        int n;
        int cyc;
        int wrote;
        int stalled;
        bit stall;
        n = model_n(b, h);
        cyc = 0;
        wrote = 0;
        stalled = 0;
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.is_byte   = b;
        bus.is_half   = h;
        bus.is_word   = w;
        #1;
        chk("hs_ready", 32'(bus.req_ready), 32'd1);
        chk("hs_wr",    32'(bus.mem_wr),    32'd0);
        while (wrote < n) begin
            @(negedge clk);
            if (hold) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = $urandom;
                bus.req_data  = $urandom;
                bus.is_byte   = 1'($urandom_range(0, 1));
                bus.is_half   = 1'($urandom_range(0, 1));
            end else begin
                bus.req_valid = 1'b0;
            end
            stall = (wrote == stall_at) && (stalled < stall_len);
            rdy = !stall;
            #1;
            cyc++;
            if (stall) begin
                stalled++;
                chk("stall_wr",   32'(bus.mem_wr), 32'd0);
                chk("stall_done", 32'(bus.done),   32'd0);
                chk("stall_a",    bus.mem_a,       32'd0);
            end else begin
                chk("wr",    32'(bus.mem_wr),   32'd1);
                chk("addr",  bus.mem_a,         a + 32'(wrote));
                chk("byte",  32'(bus.mem_dout), (d >> (8 * wrote)) & 32'hFF);
                chk("done",  32'(bus.done),     32'(wrote == n - 1));
                chk("busy",  32'(bus.req_ready), 32'd0);
                wrote++;
            end
        end
        chk("latency", 32'(cyc), 32'(n + stalled));
    endtask

    initial begin
        int n_r;
        rst = 1'b1;
        rdy = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.is_byte   = 1'b0;
        bus.is_half   = 1'b0;
        bus.is_word   = 1'b0;

        // Power-on reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_wr",    32'(bus.mem_wr),    32'd0);
        chk("rst_a",     bus.mem_a,          32'd0);
        chk("rst_dout",  32'(bus.mem_dout),  32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        idle_check(2, "idle0");

        // SW, SB and SH truncation, stall, wrap with no qualifier
        do_store(32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 9, 0, 1'b0);
        idle_check(1, "after_sw");
        do_store(32'h0000_0020, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 9, 0, 1'b0);
        idle_check(1, "after_sb");
        do_store(32'h0000_0022, 32'hFFFF_8001, 1'b0, 1'b1, 1'b0, 9, 0, 1'b0);
        idle_check(1, "after_sh");
        do_store(32'h0000_3000, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 2, 3, 1'b0);
        idle_check(1, "after_stall");
        do_store(32'hFFFF_FFFE, 32'h1122_3344, 1'b0, 1'b0, 1'b0, 9, 0, 1'b0);
        idle_check(1, "after_wrap");

        // Input isolation: req_* scrambled with valid held; next accept right after done
        do_store(32'h0000_4001, 32'hA5B6_C7D8, 1'b0, 1'b0, 1'b1, 9, 0, 1'b1);
        do_store(32'h0000_5000, 32'h0102_0304, 1'b0, 1'b1, 1'b0, 9, 0, 1'b0);
        idle_check(1, "after_iso");

        // Reset mid-word: two bytes out, then reset held 2 cycles with rdy_in low
        @(negedge clk);
        rdy = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_6000;
        bus.req_data  = 32'h7766_5544;
        bus.is_byte   = 1'b0;
        bus.is_half   = 1'b0;
        bus.is_word   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            #1;
            chk("pre_rst_wr", 32'(bus.mem_wr), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_wr",    32'(bus.mem_wr),    32'd0);
        chk("mid_rst_a",     bus.mem_a,          32'd0);
        chk("mid_rst_done",  32'(bus.done),      32'd0);
        idle_check(4, "post_rst");

        // Randomized stores, any combination of size bits, random stalls
        for (int t = 0; t < 40; t++) begin
            bit rb;
            bit rh;
            rb = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            n_r = model_n(rb, rh);
            do_store($urandom, $urandom, rb, rh, 1'($urandom_range(0, 1)),
                     $urandom_range(0, n_r - 1), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0)
                idle_check(1, "rand_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/store_serializer.md
# store_serializer

Store-side counterpart of the load-path sign extender in the CPU's memory unit. Accepts one 32-bit store request with a byte/half/word size qualifier, truncates the data to the requested width, and writes it little-endian, one byte per cycle, over the 8-bit RAM write port. It sits between the load/store unit and the memory controller's RAM interface.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, store data width (register width)
- clk_in  input  1  system clock; all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global ready; when low the block freezes (no state change, mem_wr=0)
- req_valid  input  1  store request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_addr  input  ADDR_WIDTH  byte address of lowest byte
- req_data  input  DATA_WIDTH  register value to store
- is_byte  input  1  store 1 byte (SB)
- is_half  input  1  store 2 bytes (SH)
- is_word  input  1  store 4 bytes (SW)
- mem_a  output  ADDR_WIDTH  RAM byte address
- mem_dout  output  8  RAM write byte
- mem_wr  output  1  RAM write strobe, one byte per cycle
- done  output  1  one-cycle pulse coincident with final byte write

## Operation
- States: IDLE, WRITE.
- IDLE: req_ready=1, mem_wr=0. On rising edge with rdy_in=1 and req_valid=1: latch req_addr, req_data, byte count N, clear index idx=0, go to WRITE.
- Size decode priority: is_byte -> N=1; else is_half -> N=2; else N=4 (is_word or no qualifier set). Bits above 8*N of req_data are discarded (truncation, inverse of load sign extension).
- WRITE, each cycle with rdy_in=1: mem_wr=1, mem_a=base+idx (mod 2^ADDR_WIDTH), mem_dout=data[8*idx+7:8*idx]; idx increments at edge. When idx=N-1: done=1 in same cycle, return to IDLE at edge.
- WRITE with rdy_in=0: mem_wr=0, done=0, idx and latched fields held; resume on next rdy_in=1 cycle with same idx.
- Inputs on req_* are ignored outside IDLE; latched copies drive all writes (requester may change req_* after handshake).
- Address arithmetic wraps: base 0xFFFFFFFF, word store writes 0xFFFFFFFF, 0x00000000, 0x00000001, 0x00000002.
- No alignment check; misaligned half/word stores written byte-wise as-is.

## Timing
- Reset (rst_in=1 at edge): state=IDLE, idx=0, latched regs=0; outputs after reset: req_ready=1, mem_wr=0, mem_a=0, mem_dout=0, done=0. Reset wins over rdy_in and over a mid-store WRITE; partially written bytes are not retried.
- rst_in sampled regardless of rdy_in.
- Handshake accepted at edge k; first byte driven in cycle k+1; byte i in cycle k+1+i (no rdy_in stalls); done with byte N-1 in cycle k+N; req_ready=1 again in cycle k+N+1.
- Throughput: one request per N+1 cycles; no back-to-back acceptance in the done cycle.
- mem_a/mem_dout driven combinationally from registered state; in IDLE and stalled cycles mem_a=0, mem_dout=0.
- done never asserted when mem_wr=0.

## Test plan
- Reset: hold rst_in 2 cycles mid-WRITE of a word store -> next cycle req_ready=1, mem_wr=0, mem_a=0, done=0; no further writes.
- SW: addr=0x1000, data=0xDEADBEEF, is_word -> writes (0x1000,0xEF),(0x1001,0xBE),(0x1002,0xAD),(0x1003,0xDE) on consecutive cycles, done with 4th, req_ready back next cycle.
- SB/SH truncation: SB addr=0x20, data=0x12345678 -> single write (0x20,0x78), done same cycle; SH addr=0x22, data=0xFFFF8001 -> (0x22,0x01),(0x23,0x80).
- Stall: word store, rdy_in low for 3 cycles after 2nd byte -> mem_wr=0 those cycles, then bytes 3,4 resume with unchanged addresses; total 7 cycles handshake-to-done.
- Wrap and no-qualifier: addr=0xFFFFFFFE, data=0x11223344, no size bits -> 4 writes at 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1 with 0x44,0x33,0x22,0x11.
- Input isolation: change req_data/req_addr and hold req_valid=1 during WRITE -> written bytes match originally latched values; second request accepted only in the cycle after done.
